// File: rtl/game_control_if.sv
// Bundle of game-sequencer inputs (buttons, ball and block-field flags) and
// outputs (ball control, counters, LED state code) between the sequencer and its neighbours.
interface game_control_if #(
  parameter int BLK_W = 6
);
  // No valid/ready pairs here: inputs are levels sampled every clock (tick is a
  // one-cycle pulse); ball_start and ball_reset are one-cycle pulses; all else are levels.
  logic             btn_start;
  logic             hit_lava;
  logic             hit_block;
  logic [BLK_W-1:0] blocks_left;
  logic             tick;
  logic             ball_start;
  logic             ball_reset;
  logic             ball_endgame;
  logic [2:0]       lives;
  logic [13:0]      score;
  logic [2:0]       game_state;

  modport master (
    output btn_start, hit_lava, hit_block, blocks_left, tick,
    input  ball_start, ball_reset, ball_endgame, lives, score, game_state
  );

  modport slave (
    input  btn_start, hit_lava, hit_block, blocks_left, tick,
    output ball_start, ball_reset, ball_endgame, lives, score, game_state
  );
endinterface

// File: rtl/game_control.sv
// Breakout game sequencer: serve / play / life-lost / game-over / win, with
// lives and saturating score counters. All outputs are registered.
module game_control #(
  parameter int LIVES_INIT  = 3,
  parameter int SERVE_TICKS = 60,
  parameter int POINTS      = 10,
  parameter int SCORE_MAX   = 9999,
  parameter int BLK_W       = 6
) (
  input  logic          clock,
  input  logic          reset,
  game_control_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_LOST  = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } state_t;

  localparam int               CNT_W     = $clog2(SERVE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(SERVE_TICKS);
  localparam logic [2:0]       LIVES_RST = 3'(LIVES_INIT);
  localparam logic [13:0]      SCORE_CAP = 14'(SCORE_MAX);
  localparam logic [14:0]      SCORE_ADD = 15'(POINTS);
  localparam logic [BLK_W-1:0] NO_BLOCKS = '0;

  state_t           state;
  logic [CNT_W-1:0] serve_cnt;
  logic [2:0]       lives_r;
  logic [13:0]      score_r;
  logic             ball_start_r;
  logic             ball_reset_r;
  logic             ball_endgame_r;
  logic             start_q;
  logic             lava_q;
  logic             block_q;

  logic             rise_start;
  logic             rise_lava;
  logic             rise_block;
  logic [CNT_W-1:0] serve_cnt_next;
  logic [14:0]      score_sum;
  logic [13:0]      score_sat;

  assign rise_start     = bus.btn_start & ~start_q;
  assign rise_lava      = bus.hit_lava  & ~lava_q;
  assign rise_block     = bus.hit_block & ~block_q;
  assign serve_cnt_next = serve_cnt + {{(CNT_W-1){1'b0}}, bus.tick};
  assign score_sum      = {1'b0, score_r} + SCORE_ADD;
  assign score_sat      = (score_sum > {1'b0, SCORE_CAP}) ? SCORE_CAP : score_sum[13:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      serve_cnt      <= '0;
      lives_r        <= LIVES_RST;
      score_r        <= '0;
      ball_start_r   <= 1'b0;
      ball_reset_r   <= 1'b0;
      ball_endgame_r <= 1'b0;
      // A button held through reset has to be released before it counts.
      start_q        <= 1'b1;
      lava_q         <= 1'b0;
      block_q        <= 1'b0;
    end else begin
      start_q      <= bus.btn_start;
      lava_q       <= bus.hit_lava;
      block_q      <= bus.hit_block;
      ball_start_r <= 1'b0;
      ball_reset_r <= 1'b0;

      case (state)
        S_IDLE: begin
          ball_endgame_r <= 1'b0;
          if (rise_start) begin
            lives_r      <= LIVES_RST;
            score_r      <= '0;
            serve_cnt    <= '0;
            ball_reset_r <= 1'b1;
            state        <= S_SERVE;
          end
        end

        S_SERVE: begin
          // Launch fires on the edge that samples the last tick, so ball_start
          // shows up in the cycle right after that tick.
          serve_cnt <= serve_cnt_next;
          if (rise_start || (serve_cnt_next >= CNT_LIMIT)) begin
            ball_start_r <= 1'b1;
            state        <= S_PLAY;
          end
        end

        S_PLAY: begin
          if (rise_block) begin
            score_r <= score_sat;
          end
          if (bus.blocks_left == NO_BLOCKS) begin
            ball_endgame_r <= 1'b1;
            state          <= S_WIN;
          end else if (rise_lava && (lives_r != 3'd0)) begin
            lives_r <= lives_r - 3'd1;
            if (lives_r == 3'd1) begin
              ball_endgame_r <= 1'b1;
              state          <= S_OVER;
            end else begin
              // Re-serve pulse coincides with the single LOST cycle.
              ball_reset_r <= 1'b1;
              serve_cnt    <= '0;
              state        <= S_LOST;
            end
          end
        end

        S_LOST: begin
          serve_cnt <= '0;
          state     <= S_SERVE;
        end

        S_OVER, S_WIN: begin
          ball_endgame_r <= 1'b1;
          if (rise_start) begin
            ball_endgame_r <= 1'b0;
            lives_r        <= LIVES_RST;
            score_r        <= '0;
            serve_cnt      <= '0;
            ball_reset_r   <= 1'b1;
            state          <= S_SERVE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ball_start   = ball_start_r;
  assign bus.ball_reset   = ball_reset_r;
  assign bus.ball_endgame = ball_endgame_r;
  assign bus.lives        = lives_r;
  assign bus.score        = score_r;
  assign bus.game_state   = state;

  a_pulse_exclusive: assert property (@(posedge clock) disable iff (reset)
    !(ball_start_r && ball_reset_r));

  a_score_capped: assert property (@(posedge clock) disable iff (reset)
    score_r <= SCORE_CAP);

endmodule
